cmplx_result_reader: RTL and testbench

- Read-back engine for the complex-product result memories: the real and imaginary single-port RAMs written by the product/sum pipeline.
- On a start command it sequences read addresses over a window of result words and captures the registered RAM outputs into a 2-entry buffer.
- It streams (real, imag) pairs downstream on a valid/ready interface with a last flag.
- It asserts busy so the write side can hold off its write enable during readout.

---
 rtl/cmplx_result_reader.sv | 158 +++++++++++++++
 tb/tb_cmplx_result_reader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cmplx_result_reader.sv
// Read-back engine for the real/imaginary complex-product result RAMs.
// It walks a window of result addresses, captures the registered RAM
// outputs into a 2-entry buffer and streams (real, imag, last) downstream
// on a valid/ready interface. busy tells the write side to hold off.
module cmplx_result_reader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_rd,
   input  logic [DATA_WIDTH-1:0] ram_q_real,
   input  logic [DATA_WIDTH-1:0] ram_q_imag,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_real,
   output logic [DATA_WIDTH-1:0] m_imag,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      DRAIN  = 2'd2,
      FINISH = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH:0] REMAIN_ONE = (ADDR_WIDTH+1)'(1);

   state_t                  state;
   state_t                  next_state;
   logic [ADDR_WIDTH:0]     remaining;
   logic                    in_flight;
   logic                    in_flight_last;
   logic [DATA_WIDTH-1:0]   buf_real [2];
   logic [DATA_WIDTH-1:0]   buf_imag [2];
   logic                    buf_last [2];
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              count;
   logic                    pop;
   logic                    issue;
   logic [2:0]              credit_used;
   logic                    accept_start;

   assign accept_start = (state == IDLE) && start;

   // A word leaves the buffer whenever the head is valid and downstream takes it.
   // Counting that departure in the credit check is what sustains 1 word/cycle;
   // m_valid itself stays purely registered.
   always_comb begin
      pop         = (count != 2'd0) && m_ready;
      credit_used = {1'b0, count} + {2'b00, in_flight} - {2'b00, pop};
      issue       = (state == READ) && (credit_used < 3'd2);
   end

   // Next-state logic for the window sequencer.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               next_state = (len == '0) ? FINISH : READ;
            end
         end
         READ: begin
            if (issue && (remaining == REMAIN_ONE)) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && m_last) begin
               next_state = FINISH;
            end
         end
         FINISH: begin
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Address walker, remaining-issue counter and in-flight read tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_addr       <= '0;
         remaining      <= '0;
         in_flight      <= 1'b0;
         in_flight_last <= 1'b0;
      end else begin
         if (accept_start) begin
            ram_addr  <= base_addr;
            remaining <= len;
         end else if (issue) begin
            ram_addr  <= ram_addr + ADDR_WIDTH'(1);
            remaining <= remaining - REMAIN_ONE;
         end
         in_flight      <= issue;
         in_flight_last <= issue && (remaining == REMAIN_ONE);
      end
   end

   // Two-entry capture buffer; the credit rule means a capture never finds it full.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            buf_real[i] <= '0;
            buf_imag[i] <= '0;
            buf_last[i] <= 1'b0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (in_flight) begin
            buf_real[wr_ptr] <= ram_q_real;
            buf_imag[wr_ptr] <= ram_q_imag;
            buf_last[wr_ptr] <= in_flight_last;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({in_flight, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Output view of the buffer head and status flags.
   always_comb begin
      ram_rd  = issue;
      m_valid = (count != 2'd0);
      m_real  = buf_real[rd_ptr];
      m_imag  = buf_imag[rd_ptr];
      m_last  = m_valid && buf_last[rd_ptr];
      busy    = (state != IDLE);
      done    = (state == FINISH);
   end

endmodule

// File: tb/tb_cmplx_result_reader.sv
// Self-checking bench for cmplx_result_reader: a registered RAM model,
// a table of read windows and a scoreboard of expected (real, imag, last).
module tb_cmplx_result_reader;

   localparam int DW = 32;
   localparam int AW = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   len;
   logic [AW-1:0] ram_addr;
   logic          ram_rd;
   logic [DW-1:0] ram_q_real;
   logic [DW-1:0] ram_q_imag;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_real;
   logic [DW-1:0] m_imag;
   logic          m_last;
   logic          busy;
   logic          done;

   cmplx_result_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .len        (len),
      .ram_addr   (ram_addr),
      .ram_rd     (ram_rd),
      .ram_q_real (ram_q_real),
      .ram_q_imag (ram_q_imag),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_real     (m_real),
      .m_imag     (m_imag),
      .m_last     (m_last),
      .busy       (busy),
      .done       (done)
   );

   // 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered-output RAM pair: real[k] = k<<21, imag[k] = -(k<<21).
   always @(posedge clk) begin
      if (ram_rd) begin
         ram_q_real <= 32'(ram_addr) << 21;
         ram_q_imag <= -(32'(ram_addr) << 21);
      end
   end

   typedef struct {
      logic [DW-1:0] re;
      logic [DW-1:0] im;
      logic          last;
   } exp_t;

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   wlen;
      int            stall_lo;
      int            stall_hi;
      int            restart;
      int            exp_done;
      int            exp_rds;
   } vec_t;

   exp_t expq[$];
   int   vectors;
   int   miscompares;

   task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_m_valid"},  32'(m_valid),  32'd0);
      checkOutput({tag, "_ram_rd"},   32'(ram_rd),   32'd0);
      checkOutput({tag, "_busy"},     32'(busy),     32'd0);
      checkOutput({tag, "_done"},     32'(done),     32'd0);
      checkOutput({tag, "_m_last"},   32'(m_last),   32'd0);
      checkOutput({tag, "_m_real"},   m_real,        32'd0);
      checkOutput({tag, "_m_imag"},   m_imag,        32'd0);
      checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
   endtask

   // Runs one window starting in the current (idle) cycle, checking every cycle.
   task automatic applyStimulus(input vec_t v);
      int            rd_count;
      logic [AW-1:0] a;
      exp_t          e;
      exp_t          h;
      rd_count  = 0;
      start     = 1'b1;
      base_addr = v.base;
      len       = v.wlen;
      m_ready   = 1'b1;
      for (int i = 0; i < int'(v.wlen); i++) begin
         a      = v.base + AW'(i);
         e.re   = 32'(a) << 21;
         e.im   = -(32'(a) << 21);
         e.last = (i == int'(v.wlen) - 1);
         expq.push_back(e);
      end
      for (int cyc = 1; cyc <= v.exp_done + 1; cyc++) begin
         @(posedge clk);
         #1;
         start   = 1'b0;
         m_ready = !(cyc >= v.stall_lo && cyc <= v.stall_hi);
         if (cyc == v.restart) begin
            start     = 1'b1;
            base_addr = 4'd5;
            len       = 5'd3;
         end
         #1;
         if (ram_rd) begin
            a = v.base + AW'(rd_count);
            checkOutput("ram_addr", 32'(ram_addr), 32'(a));
            rd_count++;
         end
         if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
               checkOutput("unexpected_word", 32'(m_valid), 32'd0);
            end else begin
               h = expq.pop_front();
               checkOutput("m_real", m_real, h.re);
               checkOutput("m_imag", m_imag, h.im);
               checkOutput("m_last", 32'(m_last), 32'(h.last));
            end
         end else if (m_valid && expq.size() != 0) begin
            h = expq[0];
            checkOutput("held_m_real", m_real, h.re);
         end
         if (v.stall_hi > 0 && cyc == v.stall_hi) begin
            checkOutput("reads_before_stall", 32'(rd_count), 32'd2);
         end
         checkOutput("busy", 32'(busy), 32'(cyc <= v.exp_done));
         checkOutput("done", 32'(done), 32'(cyc == v.exp_done));
      end
      checkOutput("read_count", 32'(rd_count), 32'(v.exp_rds));
      checkOutput("words_left", 32'(expq.size()), 32'd0);
      expq.delete();
   endtask

   // Reset asserted in cycle 4 of a len-8 window aborts it cleanly.
   task automatic resetMidWindow();
      start     = 1'b1;
      base_addr = 4'd0;
      len       = 5'd8;
      m_ready   = 1'b1;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(posedge clk);
         #1;
         start = 1'b0;
         if (cyc == 4) rst = 1'b1;
         #1;
      end
      @(posedge clk);
      #2;
      checkResetOutputs("midreset");
      rst = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(posedge clk);
         #2;
         checkOutput("post_reset_done",  32'(done),    32'd0);
         checkOutput("post_reset_valid", 32'(m_valid), 32'd0);
         checkOutput("post_reset_rd",    32'(ram_rd),  32'd0);
      end
   endtask

   vec_t vecs[$];

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      start       = 1'b0;
      base_addr   = '0;
      len         = '0;
      m_ready     = 1'b1;

      //            base  len  stlo sthi rst  done rds
      vecs.push_back('{4'd0,  5'd4,  0, 0, 0,  7,  4});
      vecs.push_back('{4'd0,  5'd8,  3, 9, 0, 18,  8});
      vecs.push_back('{4'd14, 5'd4,  0, 0, 0,  7,  4});
      vecs.push_back('{4'd0,  5'd0,  0, 0, 0,  1,  0});
      vecs.push_back('{4'd0,  5'd4,  0, 0, 2,  7,  4});
      vecs.push_back('{4'd9,  5'd3,  0, 0, 0,  6,  3});
      vecs.push_back('{4'd3,  5'd16, 0, 0, 0, 19, 16});
      vecs.push_back('{4'd7,  5'd1,  0, 0, 0,  4,  1});

      repeat (3) @(posedge clk);
      #2;
      checkResetOutputs("reset");
      rst = 1'b0;
      @(posedge clk);
      #2;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
      end

      resetMidWindow();
      applyStimulus('{4'd2, 5'd8, 0, 0, 0, 11, 8});

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
